// File: rtl/br_ram_rd_wr_arb.sv
// Purpose : shares one RAM write port and one RAM read port among NumRequesters
//           clients. Each port has its own round-robin arbiter, and read data is
//           steered back to the client that issued the read.
// Latency : grants are combinational. The read response arrives RamReadLatency
//           cycles after the grant, or in the grant cycle when RamReadLatency is 0.
// Backpr. : a client waits until its ready is high. The response path has no
//           backpressure, so every client must accept rd_resp_valid on any cycle.
//
// Ports
//   clk, rst_n                                    clock, async active-low reset
//   wr_req_valid/ready/addr/data                  per-client write requests (flattened)
//   rd_req_valid/ready/addr                       per-client read requests (flattened)
//   rd_resp_valid, rd_resp_data                   per-client response pulse, shared data
//   ram_wr_valid/addr/data                        RAM write port
//   ram_rd_addr_valid/addr                        RAM read address port
//   ram_rd_data_valid/data                        RAM read data return
module br_ram_rd_wr_arb #(
   parameter  int NumRequesters  = 2,
   parameter  int Depth          = 8,
   parameter  int Width          = 8,
   parameter  int RamReadLatency = 1,
   localparam int AddrWidth      = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   input  logic [NumRequesters-1:0]             wr_req_valid,
   output logic [NumRequesters-1:0]             wr_req_ready,
   input  logic [NumRequesters*AddrWidth-1:0]   wr_req_addr,
   input  logic [NumRequesters*Width-1:0]       wr_req_data,

   input  logic [NumRequesters-1:0]             rd_req_valid,
   output logic [NumRequesters-1:0]             rd_req_ready,
   input  logic [NumRequesters*AddrWidth-1:0]   rd_req_addr,
   output logic [NumRequesters-1:0]             rd_resp_valid,
   output logic [Width-1:0]                     rd_resp_data,

   output logic                                 ram_wr_valid,
   output logic [AddrWidth-1:0]                 ram_wr_addr,
   output logic [Width-1:0]                     ram_wr_data,

   output logic                                 ram_rd_addr_valid,
   output logic [AddrWidth-1:0]                 ram_rd_addr,
   input  logic                                 ram_rd_data_valid,
   input  logic [Width-1:0]                     ram_rd_data
);

   localparam int IdWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

   // Round-robin pick: first requester strictly after 'last', modulo N.
   // The scan runs from the farthest offset down to the nearest one, so the
   // nearest valid requester is the one that remains set at the end.
   function automatic logic [NumRequesters-1:0] rr_pick(
      input logic [NumRequesters-1:0] req,
      input logic [IdWidth-1:0]       last
   );
      logic [NumRequesters-1:0] gnt;
      logic [IdWidth-1:0]       idx;
      gnt = '0;
      for (int off = NumRequesters; off >= 1; off--) begin
         idx = IdWidth'((int'(last) + off) % NumRequesters);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [IdWidth-1:0] oh2idx(input logic [NumRequesters-1:0] oh);
      logic [IdWidth-1:0] idx;
      idx = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (oh[i]) idx = idx | IdWidth'(i);
      end
      return idx;
   endfunction

   logic [IdWidth-1:0]       wr_last;
   logic [IdWidth-1:0]       rd_last;
   logic [NumRequesters-1:0] wr_gnt;
   logic [NumRequesters-1:0] rd_gnt;
   logic [IdWidth-1:0]       wr_gnt_id;
   logic [IdWidth-1:0]       rd_gnt_id;
   logic                     wr_fire;
   logic                     rd_fire;

   assign wr_gnt       = rr_pick(wr_req_valid, wr_last);
   assign rd_gnt       = rr_pick(rd_req_valid, rd_last);
   assign wr_gnt_id    = oh2idx(wr_gnt);
   assign rd_gnt_id    = oh2idx(rd_gnt);
   assign wr_fire      = |wr_req_valid;
   assign rd_fire      = |rd_req_valid;
   assign wr_req_ready = wr_gnt;
   assign rd_req_ready = rd_gnt;

   // Pointers reset to N-1 so that client 0 wins first. They move only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_last <= IdWidth'(NumRequesters - 1);
         rd_last <= IdWidth'(NumRequesters - 1);
      end else begin
         if (wr_fire) wr_last <= wr_gnt_id;
         if (rd_fire) rd_last <= rd_gnt_id;
      end
   end

   // RAM-side muxes. They drive zero when idle, so no client's address or data
   // leaks onto the RAM port.
   always_comb begin
      ram_wr_addr = '0;
      ram_wr_data = '0;
      ram_rd_addr = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (wr_gnt[i]) begin
            ram_wr_addr = wr_req_addr[i*AddrWidth +: AddrWidth];
            ram_wr_data = wr_req_data[i*Width +: Width];
         end
         if (rd_gnt[i]) ram_rd_addr = rd_req_addr[i*AddrWidth +: AddrWidth];
      end
   end

   assign ram_wr_valid      = wr_fire;
   assign ram_rd_addr_valid = rd_fire;

   // The tag pipe tracks which client owns each read in flight. It has the same
   // depth as the RAM read latency, so its head always lines up with returning data.
   logic               head_vld;
   logic [IdWidth-1:0] head_id;

   if (RamReadLatency == 0) begin : g_tag_bypass
      assign head_vld = rd_fire;
      assign head_id  = rd_gnt_id;
   end else begin : g_tag_pipe
      logic [RamReadLatency-1:0] tag_vld;
      logic [IdWidth-1:0]        tag_id [RamReadLatency];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < RamReadLatency; i++) tag_id[i] <= '0;
         end else begin
            tag_vld[0] <= rd_fire;
            tag_id[0]  <= rd_gnt_id;
            for (int i = 1; i < RamReadLatency; i++) begin
               tag_vld[i] <= tag_vld[i-1];
               tag_id[i]  <= tag_id[i-1];
            end
         end
      end

      assign head_vld = tag_vld[RamReadLatency-1];
      assign head_id  = tag_id[RamReadLatency-1];
   end

   // The response is also gated by head_vld. Reads that a reset flushed from the
   // tag pipe therefore never produce a response, whatever the RAM returns.
   always_comb begin
      rd_resp_valid = '0;
      if (ram_rd_data_valid && head_vld) rd_resp_valid[head_id] = 1'b1;
   end

   assign rd_resp_data = ram_rd_data;

   a_rd_tag_align: assert property (@(posedge clk) disable iff (!rst_n)
      ram_rd_data_valid == head_vld);
   a_wr_onehot0:   assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(wr_gnt));
   a_rd_onehot0:   assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(rd_gnt));
   a_wr_addr_rng:  assert property (@(posedge clk) disable iff (!rst_n)
      ram_wr_valid |-> (int'(ram_wr_addr) < Depth));
   a_rd_addr_rng:  assert property (@(posedge clk) disable iff (!rst_n)
      ram_rd_addr_valid |-> (int'(ram_rd_addr) < Depth));

endmodule

// File: tb/tb_br_ram_rd_wr_arb.sv
// Two arbiters (RamReadLatency 1 and 2, N=4) receive the same client stimulus.
// Each arbiter drives its own behavioural read-first RAM with matching latency.
module tb_br_ram_rd_wr_arb;

   localparam int N  = 4;
   localparam int AW = 3;
   localparam int W  = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  wr_vld;
   logic [N*AW-1:0] wr_addr;
   logic [N*W-1:0]  wr_data;
   logic [N-1:0]  rd_vld;
   logic [N*AW-1:0] rd_addr;

   logic [N-1:0]  wr_rdy [2];
   logic [N-1:0]  rd_rdy [2];
   logic [N-1:0]  resp_v [2];
   logic [W-1:0]  resp_d [2];
   logic          ram_wv [2];
   logic [AW-1:0] ram_wa [2];
   logic [W-1:0]  ram_wd [2];
   logic          ram_rv [2];
   logic [AW-1:0] ram_ra [2];

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = g + 1;
      logic [W-1:0] mem [8];
      logic [L-1:0] pv;
      logic [W-1:0] pd [L];

      br_ram_rd_wr_arb #(
         .NumRequesters (N),
         .Depth         (8),
         .Width         (W),
         .RamReadLatency(L)
      ) u_dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .wr_req_valid     (wr_vld),
         .wr_req_ready     (wr_rdy[g]),
         .wr_req_addr      (wr_addr),
         .wr_req_data      (wr_data),
         .rd_req_valid     (rd_vld),
         .rd_req_ready     (rd_rdy[g]),
         .rd_req_addr      (rd_addr),
         .rd_resp_valid    (resp_v[g]),
         .rd_resp_data     (resp_d[g]),
         .ram_wr_valid     (ram_wv[g]),
         .ram_wr_addr      (ram_wa[g]),
         .ram_wr_data      (ram_wd[g]),
         .ram_rd_addr_valid(ram_rv[g]),
         .ram_rd_addr      (ram_ra[g]),
         .ram_rd_data_valid(pv[L-1]),
         .ram_rd_data      (pd[L-1])
      );

      // Read-first RAM: the read samples mem before this edge's write lands.
      always_ff @(posedge clk) begin
         if (ram_wv[g]) mem[ram_wa[g]] <= ram_wd[g];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pv <= '0;
         end else begin
            pv[0] <= ram_rv[g];
            pd[0] <= mem[ram_ra[g]];
            for (int i = 1; i < L; i++) begin
               pv[i] <= pv[i-1];
               pd[i] <= pd[i-1];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_vld  = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_vld  = '0;
      rd_addr = '0;

      // Reset state
      #12;
      check("rst_resp_v1", 32'(resp_v[0]), 0);
      check("rst_resp_v2", 32'(resp_v[1]), 0);
      check("rst_ram_wv",  32'(ram_wv[0]), 0);
      check("rst_ram_rv",  32'(ram_rv[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four clients request reads continuously, so grants rotate from 0.
      rd_vld = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("rr_all_l1", 32'(rd_rdy[0]), 32'(1) << (i % 4));
         check("rr_all_l2", 32'(rd_rdy[1]), 32'(1) << (i % 4));
         tick();
      end
      rd_vld = '0;
      tick(); tick(); tick();

      // Client 1 writes A5 to addr 5, then client 2 reads addr 5.
      wr_vld = 4'b0010; wr_addr[3 +: 3] = 3'd5; wr_data[8 +: 8] = 8'hA5;
      #1;
      check("wr_gnt_c1",  32'(wr_rdy[0]), 32'b0010);
      check("ram_wv",     32'(ram_wv[0]), 1);
      check("ram_wa",     32'(ram_wa[0]), 5);
      check("ram_wd",     32'(ram_wd[0]), 32'hA5);
      tick();
      wr_vld = '0;
      rd_vld = 4'b0100; rd_addr[6 +: 3] = 3'd5;
      #1;
      check("rd_gnt_c2",  32'(rd_rdy[0]), 32'b0100);
      check("ram_ra",     32'(ram_ra[0]), 5);
      tick();
      rd_vld = '0;
      #1;
      check("l1_resp_v",  32'(resp_v[0]), 32'b0100);
      check("l1_resp_d",  32'(resp_d[0]), 32'hA5);
      check("l2_not_yet", 32'(resp_v[1]), 0);
      tick(); #1;
      check("l2_resp_v",  32'(resp_v[1]), 32'b0100);
      check("l2_resp_d",  32'(resp_d[1]), 32'hA5);
      check("l1_pulse",   32'(resp_v[0]), 0);

      // The write pointer is at 1 and only client 0 is valid, so the grant wraps to 0.
      tick();
      wr_vld = 4'b0001; wr_addr[0 +: 3] = 3'd3; wr_data[0 +: 8] = 8'h11;
      #1;
      check("wr_wrap_c0", 32'(wr_rdy[0]), 32'b0001);
      tick();
      // Same-cycle write of 3C and read of addr 3 (old data 11).
      wr_data[0 +: 8] = 8'h3C;
      rd_vld = 4'b0001; rd_addr[0 +: 3] = 3'd3;
      tick();
      // Second read of addr 3; client 2 writes 77 to addr 7.
      wr_vld = 4'b0100; wr_addr[6 +: 3] = 3'd7; wr_data[16 +: 8] = 8'h77;
      #1;
      check("rf_old_v",   32'(resp_v[0]), 32'b0001);
      check("rf_old_d",   32'(resp_d[0]), 32'h11);
      tick();
      wr_vld = '0; rd_vld = '0;
      #1;
      check("rf_new_d",   32'(resp_d[0]), 32'h3C);
      check("rf_old_d2",  32'(resp_d[1]), 32'h11);
      tick(); #1;
      check("rf_new_d2",  32'(resp_d[1]), 32'h3C);

      // Back-to-back reads by clients 0, 3 and 1; Lat=2 returns them in order.
      tick();
      rd_vld = 4'b0001; rd_addr[0 +: 3] = 3'd5;
      #1;
      check("b2b_g0",     32'(rd_rdy[1]), 32'b0001);
      tick();
      rd_vld = 4'b1000; rd_addr[9 +: 3] = 3'd3;
      #1;
      check("b2b_g3",     32'(rd_rdy[1]), 32'b1000);
      tick();
      rd_vld = 4'b0010; rd_addr[3 +: 3] = 3'd7;
      #1;
      check("b2b_g1",     32'(rd_rdy[1]), 32'b0010);
      check("b2b_r0_v",   32'(resp_v[1]), 32'b0001);
      check("b2b_r0_d",   32'(resp_d[1]), 32'hA5);
      check("b2b_l1_v",   32'(resp_v[0]), 32'b1000);
      check("b2b_l1_d",   32'(resp_d[0]), 32'h3C);
      tick();
      rd_vld = '0;
      #1;
      check("b2b_r3_v",   32'(resp_v[1]), 32'b1000);
      check("b2b_r3_d",   32'(resp_d[1]), 32'h3C);
      tick(); #1;
      check("b2b_r1_v",   32'(resp_v[1]), 32'b0010);
      check("b2b_r1_d",   32'(resp_d[1]), 32'h77);
      tick(); #1;
      check("b2b_drain",  32'(resp_v[1]), 0);

      // Only client 3 valid for 3 cycles, then all valid: wrap to client 0.
      rd_addr = '0;
      rd_vld  = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("solo_c3",  32'(rd_rdy[0]), 32'b1000);
         tick();
      end
      rd_vld = 4'b1111;
      #1;
      check("wrap_c0",    32'(rd_rdy[0]), 32'b0001);
      tick();
      rd_vld = '0;
      tick(); tick(); tick();

      // Reset asserted while two reads are in flight.
      rd_vld = 4'b0010;
      tick();
      rd_vld = 4'b0100;
      tick();
      rst_n  = 1'b0;
      rd_vld = '0;
      #1;
      check("flush_l1",   32'(resp_v[0]), 0);
      check("flush_l2",   32'(resp_v[1]), 0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_l1", 32'(resp_v[0]), 0);
         check("post_rst_l2", 32'(resp_v[1]), 0);
      end
      rd_vld = 4'b1111;
      wr_vld = 4'b1111;
      #1;
      check("rst_rd_ptr_l1", 32'(rd_rdy[0]), 32'b0001);
      check("rst_rd_ptr_l2", 32'(rd_rdy[1]), 32'b0001);
      check("rst_wr_ptr",    32'(wr_rdy[0]), 32'b0001);
      tick();
      rd_vld = '0;
      wr_vld = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
